clk_rst_seq: RTL and testbench
==============================

CLK_RST_SEQ -- requirements
Module: clk_rst_seq

Interface
REQ-001 Parameter NUM_DOMAINS, default 2, number of sequenced reset outputs; legal 1..5, matching the PLL clkc outputs.
REQ-002 Parameter PLL_RST_CYCLES, default 64, width in clk cycles of each pll_reset pulse; legal >=1.
REQ-003 Parameter LOCK_FILTER, default 1024, number of consecutive synchronised-lock-high cycles required before lock is accepted; legal >=1.
REQ-004 Parameter LOCK_TIMEOUT, default 65536, maximum cycles to wait for lock before a PLL reset retry; legal > LOCK_FILTER.
REQ-005 Parameter STAGGER, default 16, cycles between successive domain reset releases; legal >=1.
REQ-006 clk  input  1  free-running reference clock, the same source as the PLL refclk.
REQ-007 resetn  input  1  asynchronous, active-low reset of the whole block.
REQ-008 extlock  input  1  PLL lock indicator; asynchronous to clk.
REQ-009 sw_rst  input  1  synchronous single-cycle request for a soft reset of all domains without a PLL reset.
REQ-010 pll_reset  output  1  active-high reset to the PLL.
REQ-011 domain_rstn  output  NUM_DOMAINS  active-low domain resets; bit i belongs to clkc[i]; each downstream domain resynchronises its own bit.
REQ-012 locked  output  1  high only in state RUN.
REQ-013 retry_count  output  8  number of PLL reset retries since resetn, saturating at 255.

Function
REQ-014 extlock shall pass through a 2-flop synchroniser before any use; lk denotes the synchronised value, so extlock latency is 2 cycles.
REQ-015 The FSM shall have states PLL_RST, WAIT_LOCK, FILTER, RELEASE and RUN, with one shared cycle counter whose width is sized for the largest parameter.
REQ-016 In PLL_RST, pll_reset shall be 1 for exactly PLL_RST_CYCLES cycles; the FSM then goes to WAIT_LOCK with the counter cleared.
REQ-017 In WAIT_LOCK, lk=1 shall go to FILTER with the counter cleared.
REQ-018 In WAIT_LOCK, if LOCK_TIMEOUT cycles elapse with lk=0, the FSM shall go to PLL_RST and increment retry_count.
REQ-019 In FILTER, after LOCK_FILTER consecutive cycles of lk=1 the FSM shall go to RELEASE with the counter cleared.
REQ-020 In FILTER, any lk=0 shall return the FSM to WAIT_LOCK; the timeout counter restarts and retry_count is unchanged.
REQ-021 In RELEASE, domain_rstn[i] shall go high when the counter equals STAGGER*i, so bit 0 is released in the first RELEASE cycle.
REQ-022 Once released, a domain_rstn bit shall stay high until a lock loss, sw_rst, or resetn.
REQ-023 RELEASE shall go to RUN in the cycle after domain_rstn[NUM_DOMAINS-1] is released; locked then rises.
REQ-024 Lock loss (lk=0) in RELEASE or RUN shall drive all domain_rstn bits and locked low on the next edge, increment retry_count, and enter PLL_RST.
REQ-025 sw_rst=1 in RUN shall drive all domain_rstn bits and locked low on the next edge and enter RELEASE with the counter cleared; pll_reset stays 0 and retry_count is unchanged.
REQ-026 sw_rst in any state other than RUN shall be ignored.
REQ-027 If lock loss and sw_rst occur in the same cycle, lock loss shall win.
REQ-028 domain_rstn shall be all-zero in every state except RELEASE and RUN.
REQ-029 All outputs shall be registered, with no combinational path from any input to any output.

Reset
REQ-030 While resetn=0: state=PLL_RST, counter=0, synchroniser flops=0, pll_reset=1, domain_rstn=0, locked=0, retry_count=0.
REQ-031 resetn assertion at any time, including mid-RELEASE, shall force these values immediately (asynchronously); deassertion shall start a full PLL_RST pulse.

Verification (bench parameters: NUM_DOMAINS=3, PLL_RST_CYCLES=4, LOCK_FILTER=8, LOCK_TIMEOUT=32, STAGGER=2)
REQ-032 Release resetn and hold extlock=1 -> pll_reset high 4 cycles; domain_rstn goes 001, 011, 111 at 2-cycle spacing after 8 filtered cycles; locked=1; retry_count=0.
REQ-033 Hold extlock=0 for 100 cycles -> a pll_reset pulse every 36 cycles (4+32); retry_count reaches 2 by cycle 80 and never exceeds 255 in a long run.
REQ-034 extlock glitches low for 1 cycle at FILTER count 5 -> FSM returns to WAIT_LOCK; the filter restarts from 0; retry_count unchanged.
REQ-035 extlock drops in RUN -> domain_rstn=000 and locked=0 within 3 cycles of the drop; retry_count +1; a new pll_reset pulse of 4 cycles follows.
REQ-036 sw_rst pulse in RUN -> domain_rstn=000, then staggered re-release with no pll_reset; sw_rst together with lock loss -> PLL_RST path taken.
REQ-037 Assert resetn midway through RELEASE (domain_rstn=011) -> all outputs take their REQ-030 values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/clk_rst_seq.sv
// clk_rst_seq: PLL reset, lock qualification and staggered domain reset release.
// Ports: clk, resetn (async active-low), extlock (async PLL lock), sw_rst
// (one-cycle soft reset request); outputs pll_reset, domain_rstn[NUM_DOMAINS],
// locked (high in RUN), retry_count (saturating PLL retry count).
`timescale 1ns/1ps
module clk_rst_seq #(
    parameter int NUM_DOMAINS    = 2,
    parameter int PLL_RST_CYCLES = 64,
    parameter int LOCK_FILTER    = 1024,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STAGGER        = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   extlock,
    input  logic                   sw_rst,
    output logic                   pll_reset,
    output logic [NUM_DOMAINS-1:0] domain_rstn,
    output logic                   locked,
    output logic [7:0]             retry_count
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Last RELEASE count at which a domain bit is released; RUN is entered
    // one count later, so the counter must also hold REL_LAST + 1.
    localparam int REL_LAST = STAGGER * (NUM_DOMAINS - 1);
    localparam int CNT_MAX  = max2(max2(PLL_RST_CYCLES, LOCK_FILTER),
                                   max2(LOCK_TIMEOUT, REL_LAST + 1));
    localparam int CW       = $clog2(CNT_MAX + 1);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t PLL_LAST  = cnt_t'(PLL_RST_CYCLES - 1);
    localparam cnt_t FILT_LAST = cnt_t'(LOCK_FILTER - 1);
    localparam cnt_t TO_LAST   = cnt_t'(LOCK_TIMEOUT - 1);
    localparam cnt_t RUN_AT    = cnt_t'(REL_LAST + 1);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_FILTER,
        S_RELEASE,
        S_RUN
    } state_t;

    logic sync1;
    logic lk;

    state_t                 state;
    state_t                 state_d;
    cnt_t                   cnt;
    cnt_t                   cnt_d;
    logic [NUM_DOMAINS-1:0] rstn_d;
    logic [7:0]             retry_d;
    logic [7:0]             retry_inc;

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b0;
            lk    <= 1'b0;
        end else begin
            sync1 <= extlock;
            lk    <= sync1;
        end
    end

    assign retry_inc = (retry_count == 8'hFF) ? retry_count
                                              : retry_count + 8'd1;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        rstn_d  = domain_rstn;
        retry_d = retry_count;
        unique case (state)
            S_PLL_RST: begin
                rstn_d = '0;
                if (cnt == PLL_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + cnt_t'(1);
                end
            end
            S_WAIT_LOCK: begin
                rstn_d = '0;
                if (lk) begin
                    state_d = S_FILTER;
                    cnt_d   = '0;
                end else if (cnt == TO_LAST) begin
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                    retry_d = retry_inc;
                end else begin
                    cnt_d = cnt + cnt_t'(1);
                end
            end
            S_FILTER: begin
                rstn_d = '0;
                if (!lk) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt == FILT_LAST) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + cnt_t'(1);
                end
            end
            S_RELEASE: begin
                if (!lk) begin
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                    rstn_d  = '0;
                    retry_d = retry_inc;
                end else begin
                    // Released bits are sticky; each one rises on its slot.
                    for (int i = 0; i < NUM_DOMAINS; i++) begin
                        if (cnt == cnt_t'(STAGGER * i)) begin
                            rstn_d[i] = 1'b1;
                        end
                    end
                    if (cnt == RUN_AT) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + cnt_t'(1);
                    end
                end
            end
            S_RUN: begin
                // Lock loss is tested first so it wins over sw_rst.
                if (!lk) begin
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                    rstn_d  = '0;
                    retry_d = retry_inc;
                end else if (sw_rst) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                    rstn_d  = '0;
                end
            end
            default: begin
                state_d = S_PLL_RST;
                cnt_d   = '0;
                rstn_d  = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up
    // with the state they describe.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_PLL_RST;
            cnt         <= '0;
            pll_reset   <= 1'b1;
            domain_rstn <= '0;
            locked      <= 1'b0;
            retry_count <= 8'd0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            pll_reset   <= (state_d == S_PLL_RST);
            domain_rstn <= rstn_d;
            locked      <= (state_d == S_RUN);
            retry_count <= retry_d;
        end
    end

endmodule

// File: tb/tb_clk_rst_seq.sv
// tb_clk_rst_seq: randomized and directed stimulus for clk_rst_seq,
// checked per cycle against a phase/elapsed-time reference model.
`timescale 1ns/1ps
module tb_clk_rst_seq;

    localparam int ND = 3;
    localparam int PR = 4;
    localparam int LF = 8;
    localparam int LT = 32;
    localparam int ST = 2;

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_FILT = 2;
    localparam int P_REL  = 3;
    localparam int P_RUN  = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          extlock = 1'b0;
    logic          sw_rst = 1'b0;
    logic          pll_reset;
    logic [ND-1:0] domain_rstn;
    logic          locked;
    logic [7:0]    retry_count;

    clk_rst_seq #(
        .NUM_DOMAINS   (ND),
        .PLL_RST_CYCLES(PR),
        .LOCK_FILTER   (LF),
        .LOCK_TIMEOUT  (LT),
        .STAGGER       (ST)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .extlock    (extlock),
        .sw_rst     (sw_rst),
        .pll_reset  (pll_reset),
        .domain_rstn(domain_rstn),
        .locked     (locked),
        .retry_count(retry_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          pll;
        logic [ND-1:0] rstn;
        logic          lck;
        logic [7:0]    rc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    // Model: current phase, edges spent in it, retries, lock pipeline.
    int   ph = P_RST;
    int   t = 0;
    int   m_retry = 0;
    logic m_s1 = 1'b0;
    logic m_s2 = 1'b0;
    exp_t cur;

    function automatic exp_t expect_of(input int p, input int tt,
                                       input int r);
        exp_t e;
        e.pll = (p == P_RST);
        e.lck = (p == P_RUN);
        e.rc  = 8'(r);
        for (int i = 0; i < ND; i++) begin
            e.rstn[i] = (p == P_RUN) || (p == P_REL && tt > ST * i);
        end
        return e;
    endfunction

    task automatic lose_lock();
        ph = P_RST;
        t  = 0;
        if (m_retry < 255) m_retry++;
    endtask

    task automatic model_step();
        logic lk;
        if (!resetn) begin
            ph = P_RST;
            t = 0;
            m_retry = 0;
            m_s1 = 1'b0;
            m_s2 = 1'b0;
        end else begin
            lk   = m_s2;
            m_s2 = m_s1;
            m_s1 = extlock;
            case (ph)
                P_RST: begin
                    t++;
                    if (t == PR) begin ph = P_WAIT; t = 0; end
                end
                P_WAIT: begin
                    if (lk) begin
                        ph = P_FILT; t = 0;
                    end else begin
                        t++;
                        if (t == LT) lose_lock();
                    end
                end
                P_FILT: begin
                    if (!lk) begin
                        ph = P_WAIT; t = 0;
                    end else begin
                        t++;
                        if (t == LF) begin ph = P_REL; t = 0; end
                    end
                end
                P_REL: begin
                    if (!lk) begin
                        lose_lock();
                    end else begin
                        t++;
                        if (t == ST * (ND - 1) + 2) begin
                            ph = P_RUN; t = 0;
                        end
                    end
                end
                default: begin
                    if (!lk) lose_lock();
                    else if (sw_rst) begin ph = P_REL; t = 0; end
                end
            endcase
        end
        cur = expect_of(ph, t, m_retry);
        sb.push_back(cur);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("pll_reset", 32'(pll_reset), 32'(e.pll));
            check("domain_rstn", 32'(domain_rstn), 32'(e.rstn));
            check("locked", 32'(locked), 32'(e.lck));
            check("retry_count", 32'(retry_count), 32'(e.rc));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_model(input int p, input int tt, input string nm);
        int n = 0;
        while (!(ph == p && t == tt) && n < 500) begin
            cyc(1);
            n++;
        end
        total++;
        if (n >= 500) begin
            bad++;
            $display("FAIL %s: phase %0d/%0d not reached, wanted %0d/%0d",
                     nm, ph, t, p, tt);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cur = expect_of(P_RST, 0, 0);
        cyc(3);
        resetn  = 1'b1;
        extlock = 1'b1;
        cyc(40);

        sw_rst = 1'b1;
        cyc(1);
        sw_rst = 1'b0;
        cyc(20);

        extlock = 1'b0;
        cyc(100);
        extlock = 1'b1;
        cyc(60);

        // Lose lock briefly, then glitch lk during the filter window.
        extlock = 1'b0;
        cyc(1);
        extlock = 1'b1;
        wait_model(P_FILT, 3, "reach_filter");
        extlock = 1'b0;
        cyc(1);
        extlock = 1'b1;
        cyc(60);

        for (int i = 0; i < 600; i++) begin
            extlock = ($urandom_range(0, 99) < 96);
            sw_rst  = ($urandom_range(0, 15) == 0);
            cyc(1);
        end
        extlock = 1'b1;
        sw_rst  = 1'b0;
        cyc(60);

        // sw_rst lands in the same cycle that synchronised lock is low.
        wait_model(P_RUN, 0, "reach_run");
        extlock = 1'b0;
        cyc(2);
        sw_rst = 1'b1;
        cyc(1);
        sw_rst  = 1'b0;
        extlock = 1'b1;
        cyc(40);

        extlock = 1'b0;
        cyc(9600);
        check("retry_saturated", 32'(retry_count), 32'd255);
        extlock = 1'b1;
        cyc(10);

        wait_model(P_REL, 3, "reach_release");
        @(negedge clk);
        #1;
        check("rstn_before_reset", 32'(domain_rstn), 32'b011);
        resetn = 1'b0;
        #1;
        check("async_pll_reset", 32'(pll_reset), 32'd1);
        check("async_domain_rstn", 32'(domain_rstn), 32'd0);
        check("async_locked", 32'(locked), 32'd0);
        check("async_retry", 32'(retry_count), 32'd0);
        cyc(3);
        resetn = 1'b1;
        cyc(40);

        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
